// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary converters.
package bcd_pkg;

    // Bits per packed BCD digit
    localparam int DIG_W       = 4;
    // Reverse double-dabble correction: digits at or above this get DIG_ADJ_SUB removed
    localparam int DIG_ADJ_TH  = 8;
    localparam int DIG_ADJ_SUB = 3;
    // Largest legal decimal digit
    localparam int DIG_MAX     = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        SUB   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bcd_bin_if.sv
// Handshake/data bundle for bcd_bin. The err signal only exists when
// BCD_BIN_CHK_EN is defined.
interface bcd_bin_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  en;
    logic [4*DIGITS-1:0]   bcd_d_in;
    logic [BIN_W-1:0]      bin_d_out;
    logic                  rdy;
    logic                  busy;
`ifdef BCD_BIN_CHK_EN
    logic                  err;

    modport master (output en, bcd_d_in, input bin_d_out, rdy, busy, err);
    modport slave  (input en, bcd_d_in, output bin_d_out, rdy, busy, err);
`else
    modport master (output en, bcd_d_in, input bin_d_out, rdy, busy);
    modport slave  (input en, bcd_d_in, output bin_d_out, rdy, busy);
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational per-digit correction cell: a digit of 8 or more loses 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] d,
    output logic [DIG_W-1:0] q
);

    assign q = (d >= DIG_W'(DIG_ADJ_TH)) ? d - DIG_W'(DIG_ADJ_SUB) : d;

endmodule

// File: rtl/bcd_bin.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// Optional input range check enabled by defining BCD_BIN_CHK_EN.
module bcd_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    bcd_bin_if.slave   bus
);

    localparam int BCD_W = DIG_W * DIGITS;
    localparam int WRK_W = BCD_W + BIN_W;

    state_t                         state;
    // {bcd digits, binary result}; bits migrate from the BCD field into the binary field
    logic [WRK_W-1:0]               work;
    logic [CNT_W-1:0]               cnt;
    logic [DIGITS-1:0][DIG_W-1:0]   adj_q;

    // One correction cell per digit, all looking at the current BCD field
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (work[BIN_W + gi*DIG_W +: DIG_W]),
            .q (adj_q[gi])
        );
    end

`ifdef BCD_BIN_CHK_EN
    logic bad_in;
    logic bad_q;

    // Flag any input nibble outside 0..9
    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bus.bcd_d_in[i*DIG_W +: DIG_W] > DIG_W'(DIG_MAX)) bad_in = 1'b1;
    end
`endif

    // Conversion FSM with work register, shift counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            work          <= '0;
            cnt           <= '0;
            bus.rdy       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.bin_d_out <= '0;
`ifdef BCD_BIN_CHK_EN
            bus.err       <= 1'b0;
            bad_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.rdy <= 1'b0;
`ifdef BCD_BIN_CHK_EN
                    bus.err <= 1'b0;
`endif
                    if (bus.en) begin
                        cnt      <= '0;
                        bus.busy <= 1'b1;
`ifdef BCD_BIN_CHK_EN
                        bad_q    <= bad_in;
                        if (bad_in) begin
                            // Zeroed work reg makes DONE publish a zero result
                            work  <= '0;
                            state <= DONE;
                        end else begin
                            work  <= {bus.bcd_d_in, BIN_W'(0)};
                            state <= SETUP;
                        end
`else
                        work  <= {bus.bcd_d_in, BIN_W'(0)};
                        state <= SETUP;
`endif
                    end
                end
                SETUP: state <= SHIFT;
                SHIFT: begin
                    work <= work >> 1;
                    cnt  <= cnt + 1'b1;
                    // The final shift is not followed by a correction pass
                    state <= (cnt == CNT_W'(BIN_W-1)) ? DONE : SUB;
                end
                SUB: begin
                    work  <= {adj_q, work[BIN_W-1:0]};
                    state <= SHIFT;
                end
                DONE: begin
                    bus.bin_d_out <= work[BIN_W-1:0];
                    bus.rdy       <= 1'b1;
                    bus.busy      <= 1'b0;
`ifdef BCD_BIN_CHK_EN
                    bus.err       <= bad_q;
`endif
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_bin.sv
// Self-checking bench for bcd_bin: directed cases plus random valid codes
// against a decimal-arithmetic reference model. Range-check cases are
// compiled in when BCD_BIN_CHK_EN is defined.
module tb_bcd_bin;

    localparam int LAT = 29;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    bcd_bin_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd_bin #(.DIGITS(4), .BIN_W(14), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-away guard
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    // Reference: weight each decimal digit by its power of ten
    function automatic int ref_bin(input logic [15:0] code);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(code[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] rand_code();
        logic [15:0] c;
        for (int i = 0; i < 4; i++) c[i*4 +: 4] = 4'($urandom_range(0, 9));
        return c;
    endfunction

    // Start a conversion at the next edge (caller is #1 after an edge), optionally
    // pulse en again at edge E+dup_at, and check latency, result, busy and hold.
    task automatic conv(input logic [15:0] code, input int dup_at, input logic [15:0] dup_code,
                        input string tag);
        int lat       = -1;
        int busy_bad  = 0;
        int hold_bad  = 0;
        int prev      = int'(bus.bin_d_out);
        bus.en       = 1'b1;
        bus.bcd_d_in = code;
        @(posedge clk); #1;
        bus.en = 1'b0;
        for (int k = 1; k <= LAT + 10; k++) begin
            if (k == dup_at) begin
                bus.en       = 1'b1;
                bus.bcd_d_in = dup_code;
            end
            @(posedge clk); #1;
            bus.en = 1'b0;
            if (bus.rdy) begin
                lat = k;
                break;
            end
            if (k <= LAT - 1 && !bus.busy) busy_bad++;
            if (int'(bus.bin_d_out) != prev) hold_bad++;
        end
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_bin"}, int'(bus.bin_d_out), ref_bin(code));
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_hold"}, hold_bad, 0);
`ifdef BCD_BIN_CHK_EN
        chk({tag, "_err"}, int'(bus.err), 0);
`endif
    endtask

    // One idle cycle after rdy: rdy must already be gone, busy low
    task automatic idle_chk(input string tag);
        @(posedge clk); #1;
        chk({tag, "_rdy1"}, int'(bus.rdy), 0);
        chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    logic [15:0] dir_codes [8];
    int          rdy_seen;

    initial begin
        n_chk = 0;
        n_err = 0;
        dir_codes[0] = 16'h0000; dir_codes[1] = 16'h9999;
        dir_codes[2] = 16'h4095; dir_codes[3] = 16'h1234;
        dir_codes[4] = 16'h8888; dir_codes[5] = 16'h0999;
        dir_codes[6] = 16'h9000; dir_codes[7] = 16'h0008;

        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.bcd_d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", int'(bus.rdy), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_bin", int'(bus.bin_d_out), 0);
`ifdef BCD_BIN_CHK_EN
        chk("rst_err", int'(bus.err), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed codes including the extremes
        foreach (dir_codes[i]) begin
            conv(dir_codes[i], 0, 16'h0, "dir");
            idle_chk("dir");
        end

        // en during a conversion is ignored, then back-to-back start right after rdy
        conv(16'h1234, 10, 16'h0001, "ign");
        conv(16'h0001, 0, 16'h0, "b2b");
        idle_chk("b2b");

        // Reset mid-conversion aborts everything
        bus.en = 1'b1; bus.bcd_d_in = 16'h5678;
        @(posedge clk); #1;
        bus.en = 1'b0;
        repeat (14) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rdy", int'(bus.rdy), 0);
        chk("abort_bin", int'(bus.bin_d_out), 0);
        chk("abort_busy", int'(bus.busy), 0);
        rdy_seen = 0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (bus.rdy) rdy_seen++;
        end
        chk("abort_no_rdy", rdy_seen, 0);
        conv(16'h0042, 0, 16'h0, "post_rst");
        idle_chk("post_rst");

`ifdef BCD_BIN_CHK_EN
        // Illegal nibble: immediate rdy with err and zero result
        bus.en = 1'b1; bus.bcd_d_in = 16'h12A4;
        @(posedge clk); #1;
        bus.en = 1'b0;
        rdy_seen = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (bus.rdy) begin
                rdy_seen = 1;
                chk("bad_err", int'(bus.err), 1);
                chk("bad_bin", int'(bus.bin_d_out), 0);
                break;
            end
        end
        chk("bad_rdy", rdy_seen, 1);
        @(posedge clk); #1;
        chk("bad_err_clr", int'(bus.err), 0);
        conv(16'h0099, 0, 16'h0, "after_bad");
        idle_chk("after_bad");
`endif

        // Random valid codes against the reference model
        for (int n = 0; n < 1000; n++) begin
            conv(rand_code(), 0, 16'h0, "rnd");
            idle_chk("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
